serdes_link_ctrl: RTL and testbench
===================================

# serdes_link_ctrl

Link controller that sequences the SERDES serializer/deserializer pair inside `tt_um_serdes`. It brings the link up with a training pattern and confirms lock from received words. Once the link is up, it feeds user words into the serializer through a valid/ready handshake, inserting idle fill when no data is offered. It sits between the tile I/O glue and the shift-register datapath, and owns every serializer load strobe.

## Interface
- `WIDTH`, 8: serializer word width; one bit shifted per cycle.
- `TRAIN_PAT`, 8'hBC: training word, sent and expected during training.
- `IDLE_WORD`, 8'h00: fill word loaded in RUN when `tx_valid`=0.
- `TRAIN_WORDS`, 4: minimum words sent, and minimum consecutive matching words received, before the link goes up.
- `LOCK_TIMEOUT`, 64: maximum cycles spent in TRAIN before error.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: tile enable; low freezes all state.
- `start` in 1: level request to bring the link up and keep it up.
- `tx_data` in WIDTH: user word.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: word accepted this cycle when `tx_valid`=1.
- `ser_load` out 1: one-cycle strobe to load the serializer with `ser_word`.
- `ser_word` out WIDTH: word to load.
- `des_word` in WIDTH: deserializer output word.
- `des_valid` in 1: `des_word` strobe.
- `link_up` out 1: state==RUN.
- `train_err` out 1: sticky training-timeout flag.
- `state` out 2: IDLE=0, TRAIN=1, RUN=2, ERR=3.

## Operation
- Reset values: state IDLE; `bit_cnt`, `sent_cnt`, `match_cnt`, `timer` all 0; `link_up` 0, `train_err` 0, `ser_load` 0, `tx_ready` 0, `ser_word` 0.
- `bit_cnt` counts mod WIDTH every enabled cycle in TRAIN/RUN. It is forced to 0 in IDLE/ERR.
- Word boundary is the cycle with `bit_cnt`==0:
  - `ser_load` = (TRAIN or RUN) & boundary & `ena`.
- `ser_word`:
  - TRAIN: TRAIN_PAT.
  - RUN: `tx_data` if `tx_valid`, else IDLE_WORD. This is the only combinational input-to-output path.
  - IDLE/ERR: 0.
- `tx_ready` = RUN & boundary & `ena`. It does not depend on `tx_valid`. A transfer occurs when `tx_ready` & `tx_valid`.
- IDLE → TRAIN when `start`=1. Entering TRAIN clears `sent_cnt`, `match_cnt`, `timer` and `train_err`.
- TRAIN:
  - `sent_cnt` increments, saturating at TRAIN_WORDS, on each `ser_load`.
  - On `des_valid`: `match_cnt` increments (saturating) if `des_word`==TRAIN_PAT, else it clears to 0.
  - `timer` increments every cycle.
  - At `bit_cnt`==WIDTH-1 with `sent_cnt`≥TRAIN_WORDS and `match_cnt`≥TRAIN_WORDS → RUN.
  - Else, when `timer`==LOCK_TIMEOUT-1 → ERR, and `train_err` sets.
  - If both conditions hold in the same cycle, lock wins.
  - `start`=0 in TRAIN → IDLE immediately.
- RUN: when `start`=0, go to IDLE at the next `bit_cnt`==WIDTH-1, so the in-flight word completes. `des_*` is ignored.
- ERR → IDLE when `start`=0. `train_err` stays set until the next TRAIN entry.
- `des_valid` is ignored outside TRAIN.
- `ena`=0: all registers hold; `ser_load` and `tx_ready` are forced to 0.
- `rst_n` low in any state: immediate return to reset values, including mid-word.

## Timing
- `start` sampled high in IDLE at cycle t → TRAIN at t+1. The first `ser_load` is at t+1, then every WIDTH cycles.
- RUN entry is aligned so the first RUN `ser_load` lands exactly WIDTH cycles after the last TRAIN load. There is no gap or slip.
- `link_up` rises in the first RUN cycle and falls in the first IDLE cycle.
- Transfer latency: the accepted word appears on `ser_word` in the same cycle as `ser_load`.
- Timeout: ERR is reached LOCK_TIMEOUT cycles after TRAIN entry, absent lock.
- `timer` width is clog2(LOCK_TIMEOUT+1). Counter widths are clog2(TRAIN_WORDS+1).

## Structure
- Package `serdes_pkg`: state enum (2-bit, encodings above), default TRAIN_PAT and IDLE_WORD constants.
- Sub-module `serdes_word_timer`: `bit_cnt` plus boundary and last-bit flags, with enable and clear inputs. Everything else is in `serdes_link_ctrl`.

## Test plan
All scenarios use WIDTH=8, TRAIN_WORDS=4, LOCK_TIMEOUT=64.
- Reset: assert `rst_n` low with random inputs → all outputs 0, `state`=0.
- Loopback lock: `start`=1 at cycle 0; `des_word`=`ser_word` with `des_valid`=`ser_load` delayed 8 cycles.
  - Expect `ser_load`=0xBC at cycles 1, 9, 17, 25.
  - Expect `state`=2 and `link_up`=1 from cycle 41; first RUN load at cycle 41.
- Timeout: `start`=1, `des_valid`=0 → `state`=3 and `train_err`=1 at cycle 65.
  - Then `start`=0 → `state`=0 and `train_err` still 1.
  - Restart → `train_err` clears.
- Mismatch: in loopback, corrupt the 3rd received word to 0x00 → `match_cnt` resets, and RUN entry is delayed by 24 cycles versus the clean run.
- Data: in RUN, offer 0x5A then 0x3C, then drop `tx_valid`.
  - Expect consecutive `ser_load` words 0x5A, 0x3C, 0x00, 0x00.
  - Expect exactly one `tx_ready` pulse per 8 cycles, and exactly two transfers.
- Freeze and abort: `ena`=0 for 5 cycles mid-TRAIN → load schedule shifts by exactly 5 cycles. `rst_n` pulse mid-RUN → `link_up`=0 and `ser_load`=0 immediately.

Source files
------------

// File: rtl/serdes_pkg.sv
// serdes_pkg: link state encoding and default training/idle words shared by the SERDES link controller.
package serdes_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRAIN = 2'd1, RUN = 2'd2, ERR = 2'd3} state_t;
  localparam logic [7:0] DEF_TRAIN_PAT = 8'hBC;
  localparam logic [7:0] DEF_IDLE_WORD = 8'h00;
endpackage

// File: rtl/serdes_link_ctrl_if.sv
// serdes_link_ctrl_if: user tx handshake, serializer load and deserializer word buses of the link controller.
interface serdes_link_ctrl_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic ser_load;
  logic [WIDTH-1:0] ser_word;
  logic [WIDTH-1:0] des_word;
  logic des_valid;
  modport master(input tx_data, tx_valid, des_word, des_valid, output tx_ready, ser_load, ser_word);
  modport slave(output tx_data, tx_valid, des_word, des_valid, input tx_ready, ser_load, ser_word);
endinterface

// File: rtl/serdes_word_timer.sv
// serdes_word_timer: bit position inside the serial word, flagging the load boundary and the last bit.
module serdes_word_timer #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  output logic boundary,
  output logic last
);
  localparam int BW = $clog2(WIDTH);
  logic [BW-1:0] bit_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bit_cnt <= '0;
    else if (ena) bit_cnt <= (clr || last) ? '0 : bit_cnt + 1'b1;
  assign boundary = bit_cnt == '0;
  assign last = bit_cnt == BW'(WIDTH - 1);
endmodule

// File: rtl/serdes_link_ctrl.sv
// serdes_link_ctrl: trains the SERDES link with a known pattern, then streams user words
// into the serializer on word boundaries, filling with the idle word when nothing is offered.
module serdes_link_ctrl
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TRAIN_PAT = WIDTH'(DEF_TRAIN_PAT),
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(DEF_IDLE_WORD),
  parameter int TRAIN_WORDS = 4,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start,
  serdes_link_ctrl_if.master bus,
  output logic link_up,
  output logic train_err,
  output logic [1:0] state
);
  localparam int CW = $clog2(TRAIN_WORDS + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  state_t st, nxt;
  logic [CW-1:0] sent_cnt, match_cnt;
  logic [TW-1:0] timer;
  logic boundary, last, active, nxt_active, locked, timed_out;
  assign active = st == TRAIN || st == RUN;
  assign nxt_active = nxt == TRAIN || nxt == RUN;
  // clearing on either side of an active span keeps bit 0 aligned with the first load after TRAIN entry
  serdes_word_timer #(.WIDTH(WIDTH)) u_word_timer (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .clr(!(active && nxt_active)),
    .boundary(boundary),
    .last(last)
  );
  assign locked = last && sent_cnt >= CW'(TRAIN_WORDS) && match_cnt >= CW'(TRAIN_WORDS);
  assign timed_out = timer == TW'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else if (ena) st <= nxt;
  // lock is tested before timeout so a lock on the final timer cycle still succeeds
  always_comb
    nxt = st == IDLE  ? (start ? TRAIN : IDLE) :
          st == TRAIN ? (!start ? IDLE : locked ? RUN : timed_out ? ERR : TRAIN) :
          st == RUN   ? ((!start && last) ? IDLE : RUN) :
                        (start ? ERR : IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sent_cnt <= '0;
      match_cnt <= '0;
      timer <= '0;
      train_err <= 1'b0;
    end else if (ena) begin
      if (st == IDLE && start) begin
        sent_cnt <= '0;
        match_cnt <= '0;
        timer <= '0;
        train_err <= 1'b0;
      end else if (st == TRAIN) begin
        if (boundary && sent_cnt < CW'(TRAIN_WORDS)) sent_cnt <= sent_cnt + 1'b1;
        if (bus.des_valid)
          match_cnt <= bus.des_word != TRAIN_PAT ? '0 :
                       match_cnt < CW'(TRAIN_WORDS) ? match_cnt + 1'b1 : match_cnt;
        timer <= timer + 1'b1;
        if (nxt == ERR) train_err <= 1'b1;
      end
    end
  always_comb begin
    state = st;
    link_up = st == RUN;
    bus.ser_load = active && boundary && ena;
    bus.tx_ready = st == RUN && boundary && ena;
    bus.ser_word = st == TRAIN ? TRAIN_PAT :
                   st == RUN   ? (bus.tx_valid ? bus.tx_data : IDLE_WORD) : '0;
  end
endmodule

// File: tb/tb_serdes_link_ctrl.sv
// tb_serdes_link_ctrl: vector table for lock and data flow, hand sequences for timeout, mismatch,
// freeze and reset, then random stimulus against a word-level reference model.
module tb_serdes_link_ctrl;
  localparam logic [7:0] PAT = 8'hBC;
  logic clk = 0, rst_n = 0, ena = 0, start = 0;
  logic link_up, train_err;
  logic [1:0] state;
  serdes_link_ctrl_if #(.WIDTH(8)) bus();
  serdes_link_ctrl #(.WIDTH(8), .TRAIN_PAT(8'hBC), .IDLE_WORD(8'h00), .TRAIN_WORDS(4), .LOCK_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .bus(bus),
    .link_up(link_up), .train_err(train_err), .state(state)
  );
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    logic start, tv;
    logic [7:0] td;
    logic [1:0] st;
    logic ld, rdy, up;
    logic [7:0] wd;
  } vec_t;
  vec_t tbl[$];

  int n_tests = 0, n_fail = 0;
  int cyc, rx_n, corrupt_at, k, n_rdy, n_xfer;
  bit loop_en;
  logic hl [0:255];
  logic [7:0] hw [0:255];
  logic [7:0] loads[$];

  // reference model: position in the word is the enabled-cycle age since TRAIN entry
  int m_mode, m_age;
  bit m_err;
  bit m_rx[$];

  function automatic vec_t v(int c, logic s, logic t, logic [7:0] d, logic [1:0] es, logic ld, logic rdy, logic up, logic [7:0] wd);
    return '{c, s, t, d, es, ld, rdy, up, wd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 0; ena = 1; start = 0; loop_en = 0; corrupt_at = 0;
    bus.tx_valid = 0; bus.tx_data = 0; bus.des_valid = 0; bus.des_word = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; cyc = 0; rx_n = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.des_valid = 0;
    bus.des_word = 8'($urandom);
    if (loop_en && cyc >= 8 && hl[cyc-8]) begin
      rx_n++;
      bus.des_valid = 1;
      bus.des_word = rx_n == corrupt_at ? 8'h00 : hw[cyc-8];
    end
  endtask

  task automatic settle();
    #2;
    hl[cyc] = bus.ser_load;
    hw[cyc] = bus.ser_word;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      next_cycle();
      settle();
    end
  endtask

  function automatic int m_run();
    int r = 0;
    for (int i = m_rx.size() - 1; i >= 0 && m_rx[i]; i--) r++;
    return r;
  endfunction

  function automatic logic [13:0] m_out();
    logic bnd;
    logic [7:0] w;
    bnd = (m_mode == 1 || m_mode == 2) && m_age % 8 == 0;
    w = m_mode == 1 ? PAT : m_mode == 2 ? (bus.tx_valid ? bus.tx_data : 8'h00) : 8'h00;
    return {2'(m_mode), m_mode == 2, m_err, bnd && ena, m_mode == 2 && bnd && ena, w};
  endfunction

  task automatic m_step();
    bit lock, tout;
    if (!rst_n || !ena) return;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_age = 0; m_rx.delete(); m_err = 0; end
      1: begin
        lock = m_age % 8 == 7 && (m_age + 1) / 8 >= 4 && m_run() >= 4;
        tout = m_age == 63;
        if (bus.des_valid) m_rx.push_back(bus.des_word == PAT);
        if (!start) m_mode = 0;
        else if (lock) begin m_mode = 2; m_age++; end
        else if (tout) begin m_mode = 3; m_err = 1; end
        else m_age++;
      end
      2: if (!start && m_age % 8 == 7) m_mode = 0; else m_age++;
      default: if (!start) m_mode = 0;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(v(0,  1, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    tbl.push_back(v(1,  1, 0, 8'h00, 1, 1, 0, 0, 8'hBC));
    tbl.push_back(v(2,  1, 0, 8'h00, 1, 0, 0, 0, 8'hBC));
    tbl.push_back(v(9,  1, 0, 8'h00, 1, 1, 0, 0, 8'hBC));
    tbl.push_back(v(17, 1, 0, 8'h00, 1, 1, 0, 0, 8'hBC));
    tbl.push_back(v(25, 1, 0, 8'h00, 1, 1, 0, 0, 8'hBC));
    tbl.push_back(v(33, 1, 0, 8'h00, 1, 1, 0, 0, 8'hBC));
    tbl.push_back(v(40, 1, 0, 8'h00, 1, 0, 0, 0, 8'hBC));
    tbl.push_back(v(41, 1, 0, 8'h00, 2, 1, 1, 1, 8'h00));
    tbl.push_back(v(42, 1, 1, 8'h5A, 2, 0, 0, 1, 8'h5A));
    tbl.push_back(v(49, 1, 1, 8'h5A, 2, 1, 1, 1, 8'h5A));
    tbl.push_back(v(50, 1, 1, 8'h3C, 2, 0, 0, 1, 8'h3C));
    tbl.push_back(v(57, 1, 1, 8'h3C, 2, 1, 1, 1, 8'h3C));
    tbl.push_back(v(58, 1, 0, 8'h00, 2, 0, 0, 1, 8'h00));
    tbl.push_back(v(65, 1, 0, 8'h00, 2, 1, 1, 1, 8'h00));
    tbl.push_back(v(73, 1, 0, 8'h00, 2, 1, 1, 1, 8'h00));
    tbl.push_back(v(75, 0, 0, 8'h00, 2, 0, 0, 1, 8'h00));
    tbl.push_back(v(80, 0, 0, 8'h00, 2, 0, 0, 1, 8'h00));
    tbl.push_back(v(81, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));

    // reset dominates whatever the inputs do
    for (int i = 0; i < 4; i++) begin
      ena = 1'($urandom); start = 1'($urandom);
      bus.tx_valid = 1'($urandom); bus.tx_data = 8'($urandom);
      bus.des_valid = 1'($urandom); bus.des_word = 8'($urandom);
      @(posedge clk);
      #3;
      chk($sformatf("reset%0d", i), {state, link_up, train_err, bus.ser_load, bus.tx_ready, bus.ser_word}, 0);
    end

    // loopback lock followed by data transfers, driven from the table
    reset_dut();
    loop_en = 1; k = 0; n_rdy = 0; n_xfer = 0; loads.delete();
    for (int c = 0; c <= 81; c++) begin
      if (c > 0) next_cycle();
      if (k < tbl.size() && tbl[k].cyc == c) begin
        start = tbl[k].start; bus.tx_valid = tbl[k].tv; bus.tx_data = tbl[k].td;
      end
      settle();
      if (k < tbl.size() && tbl[k].cyc == c) begin
        chk($sformatf("vec_c%0d{st,ld,rdy,up,word}", c), {state, bus.ser_load, bus.tx_ready, link_up, bus.ser_word},
            {tbl[k].st, tbl[k].ld, tbl[k].rdy, tbl[k].up, tbl[k].wd});
        k++;
      end
      if (c >= 41 && c <= 80) begin
        n_rdy += int'(bus.tx_ready);
        n_xfer += int'(bus.tx_ready & bus.tx_valid);
        if (bus.ser_load) loads.push_back(bus.ser_word);
      end
    end
    chk("data.ready_pulses", n_rdy, 5);
    chk("data.transfers", n_xfer, 2);
    chk("data.n_loads", loads.size(), 5);
    chk("data.load_seq", {loads[1], loads[2], loads[3], loads[4]}, 32'h5A3C0000);

    // third received word corrupted: lock slips 24 cycles and ties with the timeout
    reset_dut();
    loop_en = 1; corrupt_at = 3; start = 1;
    settle();
    run_to(41); chk("mism.c41_state", state, 1);
    run_to(64); chk("mism.c64_state", state, 1);
    run_to(65);
    chk("mism.c65_state", state, 2);
    chk("mism.c65_load", bus.ser_load, 1);
    chk("mism.c65_err", train_err, 0);

    // no received words: timeout, sticky error, cleared on retrain
    reset_dut();
    start = 1;
    settle();
    run_to(64); chk("tout.c64_state", state, 1);
    run_to(65);
    chk("tout.c65_state", state, 3);
    chk("tout.c65_err", train_err, 1);
    chk("tout.c65_load", bus.ser_load, 0);
    next_cycle(); start = 0; settle();
    chk("tout.c66_state", state, 3);
    next_cycle(); settle();
    chk("tout.c67_state", state, 0);
    chk("tout.c67_err", train_err, 1);
    next_cycle(); start = 1; settle();
    next_cycle(); settle();
    chk("tout.c69_state", state, 1);
    chk("tout.c69_err", train_err, 0);
    chk("tout.c69_load", bus.ser_load, 1);

    // ena low over a word boundary shifts the load schedule by five cycles
    reset_dut();
    start = 1;
    settle();
    for (int c = 1; c <= 23; c++) begin
      next_cycle();
      ena = !(cyc >= 9 && cyc <= 13);
      settle();
      chk($sformatf("frz.c%0d_load", cyc), bus.ser_load, (cyc == 1 || cyc == 14 || cyc == 22) ? 1 : 0);
    end
    chk("frz.state", state, 1);

    // asynchronous reset in the middle of a RUN load cycle
    reset_dut();
    loop_en = 1; start = 1;
    settle();
    run_to(49);
    chk("arst.c49_load", bus.ser_load, 1);
    rst_n = 0;
    #1;
    chk("arst.outputs", {state, link_up, bus.ser_load, bus.tx_ready, train_err}, 0);

    // random traffic against the reference model
    m_mode = 0; m_age = 0; m_err = 0; m_rx.delete();
    start = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      m_step();
      #1;
      rst_n = (i != 0) && ($urandom_range(199) != 0);
      ena = $urandom_range(9) != 0;
      if ($urandom_range(99) == 0) start = !start;
      bus.tx_valid = 1'($urandom);
      bus.tx_data = 8'($urandom);
      bus.des_valid = $urandom_range(3) == 0;
      bus.des_word = $urandom_range(9) != 0 ? PAT : 8'($urandom);
      if (!rst_n) begin m_mode = 0; m_age = 0; m_err = 0; m_rx.delete(); end
      #2;
      chk($sformatf("rand%0d{st,up,err,ld,rdy,word}", i),
          {state, link_up, train_err, bus.ser_load, bus.tx_ready, bus.ser_word}, m_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
